// File: rtl/rescue_drone_mission_ctrl.sv
// Mission controller for the rescue drone: sequences launch, search, image
// capture, return and landing, with fault, low-battery and abort handling.
//
// state         | meaning
// --------------+-----------------------------------------------
// IDLE          | on the ground, waiting for a start command
// INIT          | sensor self-test, bounded by INIT_TIMEOUT
// TAKEOFF       | climbing until above TAKEOFF_ALT
// SEARCH        | cruising, looking for a thermal signature
// TARGET_FOUND  | hovering over a target, waiting for image result
// IMAGE_CAPTURE | hovering for CAPTURE_CYCLES while the camera runs
// RETURN_BASE   | flying home, descending to LAND_ALT
// LAND          | final descent until docked and charging
// MANUAL        | operator has control
// FAIL          | fault latched, waits for acknowledge
// MAINTENANCE   | ground service / self-test
module rescue_drone_mission_ctrl #(
  parameter int ALT_W          = 8,
  parameter int TAKEOFF_ALT    = 50,
  parameter int LAND_ALT       = 2,
  parameter int BATT_W         = 8,
  parameter int BATT_LOW       = 20,
  parameter int TIMER_W        = 16,
  parameter int INIT_TIMEOUT   = 255,
  parameter int CAPTURE_CYCLES = 1000,
  parameter int MAX_TARGETS    = 4,
  parameter int CNT_W          = $clog2(MAX_TARGETS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        i_cmd,
  input  logic              i_cmd_valid,
  input  logic [ALT_W-1:0]  i_altitude,
  input  logic [BATT_W-1:0] i_battery,
  input  logic              i_err,
  input  logic              i_sensor_ok,
  input  logic              i_man_ctrl,
  input  logic              i_thermal_found,
  input  logic [1:0]        i_img_pass,
  input  logic              i_is_charging,
  output logic [3:0]        o_state_out,
  output logic [1:0]        o_propellor_status,
  output logic              o_check_sensors,
  output logic              o_image_scan,
  output logic              o_destination,
  output logic              o_manual_control,
  output logic              o_flight_error,
  output logic              o_maintenance_req,
  output logic              o_batt_low,
  output logic [CNT_W-1:0]  o_target_count,
  output logic              o_capture_done
);

  typedef enum logic [3:0] {
    S_IDLE          = 4'd0,
    S_INIT          = 4'd1,
    S_TAKEOFF       = 4'd2,
    S_SEARCH        = 4'd3,
    S_TARGET_FOUND  = 4'd4,
    S_IMAGE_CAPTURE = 4'd5,
    S_RETURN_BASE   = 4'd6,
    S_LAND          = 4'd7,
    S_MANUAL        = 4'd8,
    S_FAIL          = 4'd9,
    S_MAINTENANCE   = 4'd10
  } state_t;

  localparam logic [1:0] PROP_OFF    = 2'b00;
  localparam logic [1:0] PROP_CLIMB  = 2'b01;
  localparam logic [1:0] PROP_CRUISE = 2'b10;
  localparam logic [1:0] PROP_HOVER  = 2'b11;

  state_t             r_state;
  logic [TIMER_W-1:0] r_timer;
  logic [CNT_W-1:0]   r_target_count;
  logic               r_batt_low;
  logic               r_capture_done;
  logic [1:0]         r_prop;
  logic               r_check_sensors;
  logic               r_image_scan;
  logic               r_destination;
  logic               r_manual_control;
  logic               r_flight_error;
  logic               r_maintenance_req;

  state_t             w_next;
  logic               w_start;
  logic               w_maint_cmd;
  logic               w_abort;
  logic               w_air_exit;
  state_t             w_air_next;
  logic               w_cap_done;
  logic               w_clear_count;
  logic [CNT_W-1:0]   w_count_sat;
  logic               w_init_tc;
  logic               w_capture_tc;
  logic               w_hold_timer;

  assign w_start      = i_cmd_valid && (i_cmd == 2'b01);
  assign w_maint_cmd  = i_cmd_valid && (i_cmd == 2'b10);
  assign w_abort      = i_cmd_valid && (i_cmd == 2'b11);
  // Shared exit for every airborne state; fault outranks battery and abort.
  assign w_air_exit   = i_err || r_batt_low || w_abort;
  assign w_air_next   = i_err ? S_FAIL : S_RETURN_BASE;
  assign w_init_tc    = (r_timer == TIMER_W'(INIT_TIMEOUT - 1));
  assign w_capture_tc = (r_timer == TIMER_W'(CAPTURE_CYCLES - 1));
  assign w_count_sat  = (r_target_count == CNT_W'(MAX_TARGETS)) ?
                        r_target_count : r_target_count + CNT_W'(1);
  assign w_hold_timer = (r_state == S_INIT) || (r_state == S_IMAGE_CAPTURE);

  // Next-state selection from the registered state and current inputs.
  always_comb begin
    w_next        = r_state;
    w_cap_done    = 1'b0;
    w_clear_count = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_next = S_INIT;
      end
      S_INIT: begin
        if (i_err) begin
          w_next = S_FAIL;
        end else if (i_sensor_ok) begin
          w_next        = S_TAKEOFF;
          w_clear_count = 1'b1;
        end else if (w_init_tc) begin
          w_next = S_FAIL;
        end
      end
      S_TAKEOFF: begin
        if (w_air_exit) w_next = w_air_next;
        else if (i_altitude > ALT_W'(TAKEOFF_ALT)) w_next = S_SEARCH;
      end
      S_SEARCH: begin
        if (w_air_exit) w_next = w_air_next;
        else if (i_thermal_found) w_next = S_TARGET_FOUND;
        else if (i_man_ctrl) w_next = S_MANUAL;
      end
      S_TARGET_FOUND: begin
        if (w_air_exit) w_next = w_air_next;
        else if (i_thermal_found && (i_img_pass == 2'b10)) w_next = S_IMAGE_CAPTURE;
        else if (i_img_pass == 2'b01) w_next = S_SEARCH;
      end
      S_IMAGE_CAPTURE: begin
        if (w_air_exit) begin
          w_next = w_air_next;
        end else if (w_capture_tc) begin
          w_cap_done = 1'b1;
          w_next     = (w_count_sat == CNT_W'(MAX_TARGETS)) ? S_RETURN_BASE : S_SEARCH;
        end
      end
      S_MANUAL: begin
        if (w_air_exit) w_next = w_air_next;
        else if (!i_man_ctrl) w_next = S_SEARCH;
        else if (w_maint_cmd) w_next = S_MAINTENANCE;
      end
      S_RETURN_BASE: begin
        if (i_err) w_next = S_FAIL;
        else if (i_altitude <= ALT_W'(LAND_ALT)) w_next = S_LAND;
      end
      S_LAND: begin
        if (i_err) w_next = S_FAIL;
        else if (i_is_charging) w_next = S_IDLE;
      end
      S_FAIL: begin
        if (w_start) w_next = S_MAINTENANCE;
      end
      S_MAINTENANCE: begin
        if (i_man_ctrl) w_next = S_MANUAL;
        else if (!i_err) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register with Moore outputs registered from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state           <= S_IDLE;
      r_prop            <= PROP_OFF;
      r_check_sensors   <= 1'b0;
      r_image_scan      <= 1'b0;
      r_destination     <= 1'b0;
      r_manual_control  <= 1'b0;
      r_flight_error    <= 1'b0;
      r_maintenance_req <= 1'b0;
    end else begin
      r_state           <= w_next;
      r_prop            <= PROP_OFF;
      r_check_sensors   <= 1'b0;
      r_image_scan      <= 1'b0;
      r_destination     <= 1'b0;
      r_manual_control  <= 1'b0;
      r_flight_error    <= 1'b0;
      r_maintenance_req <= 1'b0;
      case (w_next)
        S_INIT:          r_check_sensors <= 1'b1;
        S_TAKEOFF:       r_prop <= PROP_CLIMB;
        S_SEARCH:        r_prop <= PROP_CRUISE;
        S_TARGET_FOUND: begin
          r_prop       <= PROP_HOVER;
          r_image_scan <= 1'b1;
        end
        S_IMAGE_CAPTURE: begin
          r_prop       <= PROP_HOVER;
          r_image_scan <= 1'b1;
        end
        S_RETURN_BASE: begin
          r_prop        <= PROP_CRUISE;
          r_destination <= 1'b1;
        end
        S_LAND: begin
          r_prop        <= PROP_CLIMB;
          r_destination <= 1'b1;
        end
        S_MANUAL:        r_manual_control <= 1'b1;
        S_FAIL:          r_flight_error <= 1'b1;
        S_MAINTENANCE: begin
          r_maintenance_req <= 1'b1;
          r_check_sensors   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Dwell timer, target counter, capture pulse and the battery flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_timer        <= '0;
      r_target_count <= '0;
      r_capture_done <= 1'b0;
      r_batt_low     <= 1'b0;
    end else begin
      // Terminal compares force an exit before the timer could ever wrap.
      if ((w_next == r_state) && w_hold_timer) r_timer <= r_timer + TIMER_W'(1);
      else r_timer <= '0;
      if (w_cap_done) r_target_count <= w_count_sat;
      else if (w_clear_count) r_target_count <= '0;
      r_capture_done <= w_cap_done;
      r_batt_low     <= (i_battery < BATT_W'(BATT_LOW));
    end
  end

  assign o_state_out        = r_state;
  assign o_propellor_status = r_prop;
  assign o_check_sensors    = r_check_sensors;
  assign o_image_scan       = r_image_scan;
  assign o_destination      = r_destination;
  assign o_manual_control   = r_manual_control;
  assign o_flight_error     = r_flight_error;
  assign o_maintenance_req  = r_maintenance_req;
  assign o_batt_low         = r_batt_low;
  assign o_target_count     = r_target_count;
  assign o_capture_done     = r_capture_done;

endmodule

// File: tb/tb_rescue_drone_mission_ctrl.sv
// Bench for the rescue drone mission controller: directed mission scenarios
// followed by weighted random stimulus, all compared against a mission model.
module tb_rescue_drone_mission_ctrl;

  localparam int TAKEOFF_ALT = 50;
  localparam int LAND_ALT    = 2;
  localparam int BATT_LOW    = 20;
  localparam int INIT_TO     = 255;
  localparam int CAP_CYC     = 1000;
  localparam int MAX_T       = 4;
  localparam int CNT_W       = $clog2(MAX_T + 1);

  localparam int IDLE = 0, INIT = 1, TAKEOFF = 2, SEARCH = 3, TFOUND = 4,
                 ICAP = 5, RET = 6, LAND = 7, MANUAL = 8, FAILS = 9, MAINT = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] cmd = 2'b00;
  logic cmd_valid = 1'b0;
  logic [7:0] altitude = 8'd0;
  logic [7:0] battery = 8'd100;
  logic err = 1'b0, sensor_ok = 1'b0, man_ctrl = 1'b0, thermal_found = 1'b0;
  logic [1:0] img_pass = 2'b00;
  logic is_charging = 1'b0;

  logic [3:0] state_out;
  logic [1:0] propellor_status;
  logic check_sensors, image_scan, destination, manual_control;
  logic flight_error, maintenance_req, batt_low, capture_done;
  logic [CNT_W-1:0] target_count;

  int n_vec = 0;
  int n_err = 0;

  // mission model
  int m_state, m_dwell, m_cnt;
  bit m_blow, m_cdone;

  always #5 clk = ~clk;

  rescue_drone_mission_ctrl dut (
    .clk(clk), .reset(reset), .i_cmd(cmd), .i_cmd_valid(cmd_valid),
    .i_altitude(altitude), .i_battery(battery), .i_err(err),
    .i_sensor_ok(sensor_ok), .i_man_ctrl(man_ctrl),
    .i_thermal_found(thermal_found), .i_img_pass(img_pass),
    .i_is_charging(is_charging), .o_state_out(state_out),
    .o_propellor_status(propellor_status), .o_check_sensors(check_sensors),
    .o_image_scan(image_scan), .o_destination(destination),
    .o_manual_control(manual_control), .o_flight_error(flight_error),
    .o_maintenance_req(maintenance_req), .o_batt_low(batt_low),
    .o_target_count(target_count), .o_capture_done(capture_done)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // {prop[1:0], check, scan, dest, manual, ferr, maint} for each mission phase
  function automatic logic [7:0] phase_outputs(input int st);
    case (st)
      INIT:    return 8'b00_100000;
      TAKEOFF: return 8'b01_000000;
      SEARCH:  return 8'b10_000000;
      TFOUND:  return 8'b11_010000;
      ICAP:    return 8'b11_010000;
      RET:     return 8'b10_001000;
      LAND:    return 8'b01_001000;
      MANUAL:  return 8'b00_000100;
      FAILS:   return 8'b00_000010;
      MAINT:   return 8'b00_100001;
      default: return 8'b00_000000;
    endcase
  endfunction

  task automatic model_reset();
    m_state = IDLE; m_dwell = 0; m_cnt = 0; m_blow = 0; m_cdone = 0;
  endtask

  task automatic model_step();
    int  nxt;
    bit  done;
    bit  start, abort, air;
    start = cmd_valid && (cmd == 2'b01);
    abort = cmd_valid && (cmd == 2'b11);
    air   = m_state inside {TAKEOFF, SEARCH, TFOUND, ICAP, MANUAL};
    nxt   = m_state;
    done  = 0;
    if (air && err) nxt = FAILS;
    else if (air && (m_blow || abort)) nxt = RET;
    else begin
      case (m_state)
        IDLE:    if (start) nxt = INIT;
        INIT: begin
          if (err) nxt = FAILS;
          else if (sensor_ok) begin nxt = TAKEOFF; m_cnt = 0; end
          else if (m_dwell + 1 == INIT_TO) nxt = FAILS;
        end
        TAKEOFF: if (altitude > TAKEOFF_ALT) nxt = SEARCH;
        SEARCH:  if (thermal_found) nxt = TFOUND; else if (man_ctrl) nxt = MANUAL;
        TFOUND:  if (thermal_found && img_pass == 2'b10) nxt = ICAP;
                 else if (img_pass == 2'b01) nxt = SEARCH;
        ICAP: begin
          if (m_dwell + 1 == CAP_CYC) begin
            done  = 1;
            m_cnt = (m_cnt + 1 > MAX_T) ? MAX_T : m_cnt + 1;
            nxt   = (m_cnt == MAX_T) ? RET : SEARCH;
          end
        end
        MANUAL:  if (!man_ctrl) nxt = SEARCH; else if (cmd_valid && cmd == 2'b10) nxt = MAINT;
        RET:     if (err) nxt = FAILS; else if (altitude <= LAND_ALT) nxt = LAND;
        LAND:    if (err) nxt = FAILS; else if (is_charging) nxt = IDLE;
        FAILS:   if (start) nxt = MAINT;
        MAINT:   if (man_ctrl) nxt = MANUAL; else if (!err) nxt = IDLE;
        default: nxt = IDLE;
      endcase
    end
    m_dwell = (nxt == m_state) ? m_dwell + 1 : 0;
    m_state = nxt;
    m_cdone = done;
    m_blow  = (battery < BATT_LOW);
  endtask

  task automatic compare_all();
    logic [31:0] obs, exp;
    obs = {17'd0, propellor_status, check_sensors, image_scan, destination,
           manual_control, flight_error, maintenance_req, batt_low, capture_done,
           3'(target_count)};
    exp = {17'd0, phase_outputs(m_state), m_blow, m_cdone, 3'(m_cnt)};
    check_eq("state", 32'(state_out), 32'(m_state));
    check_eq("outputs", obs, exp);
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
    end
  endtask

  task automatic to_search();
    cmd = 2'b01; cmd_valid = 1; cyc(1);
    cmd_valid = 0; sensor_ok = 1; cyc(1);
    sensor_ok = 0; altitude = 8'd51; cyc(1);
  endtask

  task automatic enter_capture();
    thermal_found = 1; img_pass = 2'b10; cyc(2);
    thermal_found = 0; img_pass = 2'b00;
  endtask

  task automatic capture(output int n);
    enter_capture();
    n = 0;
    while (state_out == 4'd5 && n < 1100) begin n++; cyc(1); end
  endtask

  task automatic async_reset_check();
    #2 reset = 1;
    #1;
    model_reset();
    check_eq("rst_state", 32'(state_out), 32'(IDLE));
    check_eq("rst_count", 32'(target_count), 32'd0);
    check_eq("rst_outs", {22'd0, propellor_status, check_sensors, image_scan,
             destination, manual_control, flight_error, maintenance_req,
             batt_low, capture_done}, 32'd0);
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    int n;
    model_reset();
    @(negedge clk);
    async_reset_check();

    // nominal launch; altitude 50 must not leave TAKEOFF
    cmd = 2'b01; cmd_valid = 1; cyc(1);
    check_eq("enter_init", 32'(state_out), INIT);
    cmd_valid = 0; cyc(2);
    sensor_ok = 1; cyc(1);
    check_eq("enter_takeoff", 32'(state_out), TAKEOFF);
    sensor_ok = 0; altitude = 8'd50; cyc(3);
    check_eq("alt50_hold", 32'(state_out), TAKEOFF);
    altitude = 8'd51; cyc(1);
    check_eq("alt51_search", 32'(state_out), SEARCH);

    // four captures complete the mission
    for (int k = 1; k <= MAX_T; k++) begin
      capture(n);
      check_eq("capture_len", 32'(n), CAP_CYC);
      check_eq("capture_cnt", 32'(target_count), 32'(k));
      check_eq("capture_pulse", 32'(capture_done), 32'd1);
      check_eq("capture_exit", 32'(state_out), (k == MAX_T) ? RET : SEARCH);
      cyc(1);
      check_eq("pulse_width", 32'(capture_done), 32'd0);
    end
    altitude = 8'd2; cyc(1);
    check_eq("land", 32'(state_out), LAND);
    is_charging = 1; cyc(1);
    is_charging = 0;
    check_eq("home_idle", 32'(state_out), IDLE);
    check_eq("home_count", 32'(target_count), MAX_T);

    // INIT timeout path
    cmd = 2'b01; cmd_valid = 1; cyc(1);
    cmd_valid = 0; n = 0;
    while (state_out == 4'd1 && n < 400) begin n++; cyc(1); end
    check_eq("init_dwell", 32'(n), INIT_TO);
    check_eq("init_fail", 32'(state_out), FAILS);
    cmd_valid = 1; cyc(1);
    cmd_valid = 0;
    check_eq("ack_maint", 32'(state_out), MAINT);
    cyc(1);
    check_eq("maint_idle", 32'(state_out), IDLE);

    // low battery mid-capture: two edges to RETURN_BASE, no credit
    to_search(); enter_capture(); cyc(500);
    battery = 8'd19; cyc(1);
    check_eq("batt_lag", 32'(state_out), ICAP);
    cyc(1);
    check_eq("batt_return", 32'(state_out), RET);
    check_eq("batt_nocount", 32'(target_count), 32'd0);
    altitude = 8'd0; cyc(1); is_charging = 1; cyc(1);
    is_charging = 0; battery = 8'd100; cyc(1);

    // fault together with low battery wins
    to_search(); enter_capture(); cyc(500);
    battery = 8'd19; err = 1; cyc(1);
    check_eq("err_wins", 32'(state_out), FAILS);
    err = 0; battery = 8'd100; cmd = 2'b01; cmd_valid = 1; cyc(1);
    cmd_valid = 0; cyc(1);

    // async reset mid-capture with two targets logged
    to_search();
    capture(n); capture(n);
    enter_capture(); cyc(300);
    check_eq("pre_rst_cnt", 32'(target_count), 32'd2);
    async_reset_check();

    // weighted random flights
    for (int i = 0; i < 30000; i++) begin
      cmd_valid     = ($urandom_range(0, 7) == 0);
      cmd           = 2'($urandom);
      err           = ($urandom_range(0, 2999) == 0);
      battery       = ($urandom_range(0, 1499) == 0) ? 8'($urandom_range(0, 19))
                                                      : 8'($urandom_range(18, 255));
      if ($urandom_range(0, 39) == 0) man_ctrl = ~man_ctrl;
      thermal_found = ($urandom_range(0, 3) != 0);
      img_pass      = 2'($urandom);
      altitude      = 8'($urandom);
      is_charging   = ($urandom_range(0, 7) == 0);
      sensor_ok     = ($urandom_range(0, 19) == 0);
      cyc(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rescue_drone_mission_ctrl.md
Name: rescue_drone_mission_ctrl

Overview:
Parametrised second-generation mission controller for the rescue drone.
- Sequences IDLE → INIT → TAKEOFF → SEARCH → capture → RETURN → LAND.
- Adds over the first generation: battery-low return, INIT timeout, bounded capture timer, saturating target counter with mission-complete return, commanded abort, and an explicit landing phase.
- Sits between the command/sensor front-end and the propulsion/camera blocks. All outputs are Moore-decoded from registered state, except capture_done, which is a registered pulse.

Parameters:
ALT_W, 8, altitude input width
TAKEOFF_ALT, 50, altitude strictly above which TAKEOFF exits to SEARCH
LAND_ALT, 2, altitude at or below which RETURN_BASE exits to LAND
BATT_W, 8, battery level width
BATT_LOW, 20, battery strictly below this value forces return while airborne
TIMER_W, 16, state timer width
INIT_TIMEOUT, 255, number of cycles allowed in INIT before FAIL (≥1)
CAPTURE_CYCLES, 1000, number of cycles spent in IMAGE_CAPTURE (≥1)
MAX_TARGETS, 4, number of captures that completes the mission (≥1)
CNT_W, $clog2(MAX_TARGETS+1), target_count width

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
cmd  in  2  command: 01 start/ack, 10 maintenance, 11 abort
cmd_valid  in  1  cmd is sampled only when this is 1
altitude  in  ALT_W  current altitude, unsigned
battery  in  BATT_W  battery level, unsigned
err  in  1  fault flag
sensor_ok  in  1  self-test passed
man_ctrl  in  1  manual-control request
thermal_found  in  1  thermal signature present
img_pass  in  2  image result: 10 pass, 01 fail, other values none
is_charging  in  1  drone is docked and charging
state_out  out  4  current state encoding
propellor_status  out  2  00 off, 01 climb, 10 cruise, 11 hover
check_sensors  out  1  self-test active
image_scan  out  1  camera active
destination  out  1  returning to base
manual_control  out  1  manual mode
flight_error  out  1  fault state
maintenance_req  out  1  maintenance state
batt_low  out  1  registered flag: battery < BATT_LOW
target_count  out  CNT_W  completed captures in the current mission
capture_done  out  1  one-cycle pulse when a capture completes

Behaviour:
- Reset (asynchronous):
  - state=IDLE, timer=0, target_count=0, capture_done=0, batt_low=0.
  - All outputs take the IDLE decode. Reset mid-mission aborts immediately; no state is retained.
- State encodings:
  - IDLE=0, INIT=1, TAKEOFF=2, SEARCH=3, TARGET_FOUND=4, IMAGE_CAPTURE=5.
  - RETURN_BASE=6, LAND=7, MANUAL=8, FAIL=9, MAINTENANCE=10. Codes 11–15 go to IDLE on the next cycle.
- State register and inputs:
  - Single registered state; next state is purely combinational from state and current inputs.
  - Every transition takes one clock edge.
  - batt_low is registered each cycle from (battery < BATT_LOW) and is the value used by the FSM, so a battery event takes effect one cycle later.
- Airborne states: TAKEOFF, SEARCH, TARGET_FOUND, IMAGE_CAPTURE, MANUAL. Common priority, highest first:
  1. err → FAIL
  2. batt_low → RETURN_BASE
  3. cmd_valid && cmd==11 → RETURN_BASE
  4. then the state-specific rule below.
- State-specific transitions:
  - IDLE: cmd_valid && cmd==01 → INIT.
  - INIT: err → FAIL; else sensor_ok → TAKEOFF (clears target_count); else timer==INIT_TIMEOUT-1 → FAIL.
  - TAKEOFF: altitude > TAKEOFF_ALT → SEARCH.
  - SEARCH: thermal_found → TARGET_FOUND; else man_ctrl → MANUAL.
  - TARGET_FOUND: thermal_found && img_pass==10 → IMAGE_CAPTURE; else img_pass==01 → SEARCH; otherwise hold.
  - IMAGE_CAPTURE: when timer==CAPTURE_CYCLES-1:
    - target_count increments, saturating at MAX_TARGETS; capture_done=1 the following cycle.
    - Go to RETURN_BASE if the incremented count == MAX_TARGETS, else SEARCH.
    - A higher-priority exit (err, batt_low, abort) abandons the capture with no increment.
  - MANUAL: err → FAIL; else !man_ctrl → SEARCH; else cmd_valid && cmd==10 → MAINTENANCE. batt_low and abort also apply.
  - RETURN_BASE: err → FAIL; else altitude <= LAND_ALT → LAND.
  - LAND: err → FAIL; else is_charging → IDLE.
  - FAIL: cmd_valid && cmd==01 → MAINTENANCE.
  - MAINTENANCE: !err && !man_ctrl → IDLE; man_ctrl → MANUAL.
- Timer:
  - Set to 0 on every state change.
  - Increments by 1 while the state is unchanged in INIT or IMAGE_CAPTURE; 0 in all other states.
  - Dwell is exactly INIT_TIMEOUT or CAPTURE_CYCLES cycles; the timer never wraps.
- Output decode (all other outputs 0):
  - IDLE: none set.
  - INIT: check_sensors.
  - TAKEOFF: prop=01.
  - SEARCH: prop=10.
  - TARGET_FOUND: prop=11, image_scan.
  - IMAGE_CAPTURE: prop=11, image_scan.
  - RETURN_BASE: prop=10, destination.
  - LAND: prop=01, destination.
  - MANUAL: manual_control.
  - FAIL: flight_error.
  - MAINTENANCE: maintenance_req, check_sensors.
- State-independent outputs: state_out = state register. target_count holds its value through RETURN_BASE, LAND and IDLE, and is cleared only on the INIT → TAKEOFF transition or by reset.

Test Plan:
- Nominal flight, defaults: cmd=01 valid, sensor_ok at cycle 3, altitude 0→51 → INIT, then TAKEOFF, then SEARCH one cycle after altitude=51; altitude=50 alone must not exit TAKEOFF.
- Capture timing: in SEARCH, thermal_found=1 and img_pass=10 → IMAGE_CAPTURE for exactly 1000 cycles, then SEARCH; target_count=1; capture_done high for exactly one cycle.
- Mission complete: four captures → after the 4th, state goes to RETURN_BASE (not SEARCH) with target_count=4; altitude=2 → LAND; is_charging=1 → IDLE with target_count still 4.
- INIT timeout: sensor_ok=0, err=0 → FAIL exactly 255 cycles after INIT entry; cmd=01 valid → MAINTENANCE; err=0 and man_ctrl=0 → IDLE.
- Priority and battery: in IMAGE_CAPTURE at timer=500, battery=19 → RETURN_BASE two edges later, no increment, no capture_done. Repeat with err=1 asserted in the same cycle as battery=19 → FAIL.
- Async reset asserted mid-IMAGE_CAPTURE with target_count=2 → immediately IDLE, target_count=0, outputs at IDLE decode without waiting for a clock edge.
